// File: rtl/override_sequencer.sv
// Override sequencer: debounces raw lock/flush/quantum requests and arbitrates
// them into registered pipeline override pulses with authentication checks.
module override_sequencer #(
  parameter int DEBOUNCE_CYCLES    = 4,
  parameter int LOCK_MIN_HOLD      = 8,
  parameter int FLUSH_PULSE_CYCLES = 2,
  parameter int COOLDOWN_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       analog_lock_req,
  input  logic       analog_flush_req,
  input  logic       quantum_req,
  input  logic       override_authentication_valid,
  input  logic [1:0] mission_profile,
  output logic       lock_out,
  output logic       flush_out,
  output logic       quantum_out,
  output logic [1:0] active_source,
  output logic       busy,
  output logic       auth_fault,
  output logic [7:0] fault_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int M1 = (LOCK_MIN_HOLD > FLUSH_PULSE_CYCLES) ?
                      LOCK_MIN_HOLD : FLUSH_PULSE_CYCLES;
  localparam int M2 = (M1 > COOLDOWN_CYCLES) ? M1 : COOLDOWN_CYCLES;
  localparam int TMAX = (M2 > 1) ? M2 : 1;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [DW-1:0] C_DB    = DW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] C_HOLD  = TW'(LOCK_MIN_HOLD);
  localparam logic [TW-1:0] C_FLUSH = TW'(FLUSH_PULSE_CYCLES);
  localparam logic [TW-1:0] C_COOL  = TW'(COOLDOWN_CYCLES);
  localparam logic [TW-1:0] C_ONE   = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUANTUM,
    S_LOCK,
    S_FLUSH,
    S_COOL
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_tmr;
  logic [TW-1:0] w_tmr_nxt;
  logic [DW-1:0] r_db [3];
  logic [DW-1:0] w_db_nxt [3];
  logic [2:0]    w_raw;
  logic [2:0]    w_qual;
  logic [2:0]    w_qnx;
  logic [1:0]    r_arm;
  logic [1:0]    w_bad;
  logic          w_fault;
  logic          w_lock_ok;
  logic          w_auth;
  logic          r_lock;
  logic          r_flush;
  logic          r_quantum;
  logic [1:0]    r_src;
  logic          r_busy;
  logic          r_fault;
  logic [7:0]    r_fcnt;
  logic          w_lock_o;
  logic          w_flush_o;
  logic          w_quantum_o;
  logic [1:0]    w_src;

  // index 0 = flush, 1 = lock, 2 = quantum
  assign w_raw     = {quantum_req, analog_lock_req, analog_flush_req};
  assign w_auth    = override_authentication_valid;
  assign w_lock_ok = w_auth || (mission_profile == 2'b11);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_db_nxt[i] = '0;
      if (w_raw[i])
        w_db_nxt[i] = (r_db[i] == C_DB) ? C_DB : r_db[i] + 1'b1;
      w_qual[i] = (r_db[i] == C_DB);
      w_qnx[i]  = (w_db_nxt[i] == C_DB);
    end
  end

  // Faults fire on the edge a request becomes qualified, one per episode
  always_comb begin
    w_bad[1] = w_qnx[1] && !w_lock_ok && r_arm[1];
    w_bad[0] = w_qnx[0] && !w_auth && r_arm[0] &&
               !(w_qnx[1] && w_lock_ok);
    w_fault  = (r_state == S_IDLE) && !w_qnx[2] && (|w_bad);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    unique case (r_state)
      S_IDLE: begin
        if (w_qual[2]) begin
          w_state_nxt = S_QUANTUM;
          w_tmr_nxt   = '0;
        end else if (w_qual[1] && w_lock_ok) begin
          w_state_nxt = S_LOCK;
          w_tmr_nxt   = C_ONE;
        end else if (w_qual[0] && w_auth) begin
          w_state_nxt = S_FLUSH;
          w_tmr_nxt   = C_ONE;
        end
      end
      S_QUANTUM: begin
        if (!quantum_req) begin
          w_state_nxt = S_COOL;
          w_tmr_nxt   = C_ONE;
        end
      end
      S_LOCK: begin
        if (w_qual[2]) begin
          w_state_nxt = S_QUANTUM;
          w_tmr_nxt   = '0;
        end else if (!analog_lock_req && r_tmr >= C_HOLD) begin
          w_state_nxt = S_COOL;
          w_tmr_nxt   = C_ONE;
        end else if (r_tmr < C_HOLD) begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      S_FLUSH: begin
        if (w_qual[2]) begin
          w_state_nxt = S_QUANTUM;
          w_tmr_nxt   = '0;
        end else if (r_tmr >= C_FLUSH) begin
          w_state_nxt = S_COOL;
          w_tmr_nxt   = C_ONE;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      S_COOL: begin
        if (w_qual[2]) begin
          w_state_nxt = S_QUANTUM;
          w_tmr_nxt   = '0;
        end else if (r_tmr >= C_COOL) begin
          w_state_nxt = S_IDLE;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_lock_o    = 1'b0;
    w_flush_o   = 1'b0;
    w_quantum_o = 1'b0;
    w_src       = 2'b00;
    unique case (w_state_nxt)
      S_QUANTUM: begin
        w_lock_o    = 1'b1;
        w_quantum_o = 1'b1;
        w_src       = 2'b11;
      end
      S_LOCK: begin
        w_lock_o = 1'b1;
        w_src    = 2'b10;
      end
      S_FLUSH: begin
        w_flush_o = 1'b1;
        w_src     = 2'b01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) r_db[i] <= '0;
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_arm     <= 2'b11;
      r_lock    <= 1'b0;
      r_flush   <= 1'b0;
      r_quantum <= 1'b0;
      r_src     <= 2'b00;
      r_busy    <= 1'b0;
      r_fault   <= 1'b0;
      r_fcnt    <= '0;
    end else begin
      for (int i = 0; i < 3; i++) r_db[i] <= w_db_nxt[i];
      for (int i = 0; i < 2; i++) begin
        if (!w_raw[i])
          r_arm[i] <= 1'b1;
        else if (w_fault && w_bad[i])
          r_arm[i] <= 1'b0;
      end
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_lock    <= w_lock_o;
      r_flush   <= w_flush_o;
      r_quantum <= w_quantum_o;
      r_src     <= w_src;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_fault   <= w_fault;
      if (w_fault && r_fcnt != 8'hFF)
        r_fcnt <= r_fcnt + 8'd1;
    end
  end

  assign lock_out      = r_lock;
  assign flush_out     = r_flush;
  assign quantum_out   = r_quantum;
  assign active_source = r_src;
  assign busy          = r_busy;
  assign auth_fault    = r_fault;
  assign fault_count   = r_fcnt;

endmodule

// File: tb/tb_override_sequencer.sv
// Directed vector bench for override_sequencer.
module tb_override_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       lk, fl, qt, au;
  logic [1:0] pr;
  logic       lock_out, flush_out, quantum_out, busy, auth_fault;
  logic [1:0] active_source;
  logic [7:0] fault_count;

  int n_cmp = 0;
  int n_bad = 0;

  // {lock, flush, quantum, src[1:0], busy, fault}
  localparam logic [6:0] O_ZERO = 7'b000_00_0_0;
  localparam logic [6:0] O_LOCK = 7'b100_10_1_0;
  localparam logic [6:0] O_QNT  = 7'b101_11_1_0;
  localparam logic [6:0] O_FLS  = 7'b010_01_1_0;
  localparam logic [6:0] O_COOL = 7'b000_00_1_0;
  localparam logic [6:0] O_FLT  = 7'b000_00_0_1;

  typedef struct {
    logic       rst, lk, fl, qt, au;
    logic [1:0] pr;
    logic [6:0] o;
    logic [7:0] fc;
  } vec_t;

  vec_t tbl[$];

  override_sequencer dut (
    .clk                           (clk),
    .reset                         (reset),
    .analog_lock_req               (lk),
    .analog_flush_req              (fl),
    .quantum_req                   (qt),
    .override_authentication_valid (au),
    .mission_profile               (pr),
    .lock_out                      (lock_out),
    .flush_out                     (flush_out),
    .quantum_out                   (quantum_out),
    .active_source                 (active_source),
    .busy                          (busy),
    .auth_fault                    (auth_fault),
    .fault_count                   (fault_count)
  );

  always #5 clk = ~clk;

  task automatic add(input int n, input logic r, l, f, q, a,
                     input logic [1:0] p, input logic [6:0] o,
                     input logic [7:0] fc);
    vec_t v;
    v.rst = r; v.lk = l; v.fl = f; v.qt = q; v.au = a;
    v.pr = p; v.o = o; v.fc = fc;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic tick(input logic r, l, f, q, a, input logic [1:0] p);
    reset = r; lk = l; fl = f; qt = q; au = a; pr = p;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [6:0] act;
    tick(v.rst, v.lk, v.fl, v.qt, v.au, v.pr);
    act = {lock_out, flush_out, quantum_out, active_source,
           busy, auth_fault};
    n_cmp++;
    if (act !== v.o) begin
      n_bad++;
      $display("FAIL vec%0d outputs: got %b want %b", idx, act, v.o);
    end
    n_cmp++;
    if (fault_count !== v.fc) begin
      n_bad++;
      $display("FAIL vec%0d fault_count: got %0d want %0d",
               idx, fault_count, v.fc);
    end
    n_cmp++;
    if (flush_out && (lock_out || quantum_out)) begin
      n_bad++;
      $display("FAIL vec%0d exclusive: flush with lock/quantum", idx);
    end
  endtask

  initial begin
    int pulses;
    // reset
    add(2, 1, 0, 0, 0, 0, 2'b00, O_ZERO, 0);
    // lock high 3 cycles only: never qualifies
    add(3, 0, 1, 0, 0, 1, 2'b00, O_ZERO, 0);
    add(2, 0, 0, 0, 0, 1, 2'b00, O_ZERO, 0);
    // lock high edges 1..6: out after edge 5 for 8 cycles, then cooldown
    add(4, 0, 1, 0, 0, 1, 2'b00, O_ZERO, 0);
    add(2, 0, 1, 0, 0, 1, 2'b00, O_LOCK, 0);
    add(6, 0, 0, 0, 0, 1, 2'b00, O_LOCK, 0);
    add(4, 0, 0, 0, 0, 1, 2'b00, O_COOL, 0);
    add(1, 0, 0, 0, 0, 1, 2'b00, O_ZERO, 0);
    // unauthorised flush: one fault after edge 4
    add(3, 0, 0, 1, 0, 0, 2'b00, O_ZERO, 0);
    add(1, 0, 0, 1, 0, 0, 2'b00, O_FLT, 1);
    add(6, 0, 0, 1, 0, 0, 2'b00, O_ZERO, 1);
    add(1, 0, 0, 0, 0, 0, 2'b00, O_ZERO, 1);
    // all three together: quantum wins
    add(4, 0, 1, 1, 1, 1, 2'b00, O_ZERO, 1);
    add(2, 0, 1, 1, 1, 1, 2'b00, O_QNT, 1);
    add(4, 0, 0, 0, 0, 1, 2'b00, O_COOL, 1);
    add(1, 0, 0, 0, 0, 1, 2'b00, O_ZERO, 1);
    // lockdown profile authorises lock without auth
    add(4, 0, 1, 0, 0, 0, 2'b11, O_ZERO, 1);
    add(1, 0, 1, 0, 0, 0, 2'b11, O_LOCK, 1);
    add(7, 0, 0, 0, 0, 0, 2'b11, O_LOCK, 1);
    add(4, 0, 0, 0, 0, 0, 2'b11, O_COOL, 1);
    add(1, 0, 0, 0, 0, 0, 2'b11, O_ZERO, 1);
    // authorised flush: fixed 2-cycle pulse while request stays high
    add(4, 0, 0, 1, 0, 1, 2'b00, O_ZERO, 1);
    add(2, 0, 0, 1, 0, 1, 2'b00, O_FLS, 1);
    add(2, 0, 0, 1, 0, 1, 2'b00, O_COOL, 1);
    add(2, 0, 0, 0, 0, 1, 2'b00, O_COOL, 1);
    add(1, 0, 0, 0, 0, 1, 2'b00, O_ZERO, 1);
    // quantum preempts the first flush cycle
    add(1, 0, 0, 1, 0, 1, 2'b00, O_ZERO, 1);
    add(3, 0, 0, 1, 1, 1, 2'b00, O_ZERO, 1);
    add(1, 0, 0, 1, 1, 1, 2'b00, O_FLS, 1);
    add(1, 0, 0, 1, 1, 1, 2'b00, O_QNT, 1);
    add(4, 0, 0, 0, 0, 1, 2'b00, O_COOL, 1);
    add(1, 0, 0, 0, 0, 1, 2'b00, O_ZERO, 1);
    // reset mid-LOCK with request held: re-debounce from zero
    add(4, 0, 1, 0, 0, 1, 2'b00, O_ZERO, 1);
    add(2, 0, 1, 0, 0, 1, 2'b00, O_LOCK, 1);
    add(1, 1, 1, 0, 0, 1, 2'b00, O_ZERO, 0);
    add(4, 0, 1, 0, 0, 1, 2'b00, O_ZERO, 0);
    add(2, 0, 1, 0, 0, 1, 2'b00, O_LOCK, 0);
    add(1, 1, 0, 0, 0, 1, 2'b00, O_ZERO, 0);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // fault_count saturation: one fault per flush episode
    pulses = 0;
    for (int e = 0; e < 259; e++) begin
      for (int c = 0; c < 5; c++) begin
        tick(0, 0, (c < 4), 0, 0, 2'b00);
        if (auth_fault) pulses++;
      end
      if (e == 253) begin
        n_cmp++;
        if (fault_count !== 8'hFE) begin
          n_bad++;
          $display("FAIL fc_254: got %0d want 254", fault_count);
        end
      end
      if (e == 254) begin
        n_cmp++;
        if (fault_count !== 8'hFF) begin
          n_bad++;
          $display("FAIL fc_255: got %0d want 255", fault_count);
        end
      end
    end
    n_cmp++;
    if (fault_count !== 8'hFF) begin
      n_bad++;
      $display("FAIL fc_sat: got %0d want 255", fault_count);
    end
    n_cmp++;
    if (pulses != 259) begin
      n_bad++;
      $display("FAIL fault_pulses: got %0d want 259", pulses);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/override_sequencer.md
OVERRIDE_SEQUENCER -- requirements
Module: override_sequencer

Parameters
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive high samples needed to qualify a raw request.
REQ-002 SHALL have parameter LOCK_MIN_HOLD, default 8: minimum cycles lock_out stays high once LOCK is entered.
REQ-003 SHALL have parameter FLUSH_PULSE_CYCLES, default 2: exact flush_out pulse width.
REQ-004 SHALL have parameter COOLDOWN_CYCLES, default 4: dead time after any override before a new lock or flush is accepted.

Interface
REQ-005 SHALL have clk, input, 1: single clock; all logic is rising-edge.
REQ-006 SHALL have reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have analog_lock_req, input, 1: raw lock override request.
REQ-008 SHALL have analog_flush_req, input, 1: raw flush override request.
REQ-009 SHALL have quantum_req, input, 1: raw quantum override request.
REQ-010 SHALL have override_authentication_valid, input, 1: authentication level flag.
REQ-011 SHALL have mission_profile, input, 2: 2'b11 = lockdown profile.
REQ-012 SHALL have lock_out, output, 1: lock override to the CPU pipeline.
REQ-013 SHALL have flush_out, output, 1: flush override to the CPU pipeline.
REQ-014 SHALL have quantum_out, output, 1: quantum override to the CPU pipeline.
REQ-015 SHALL have active_source, output, 2: 00 none, 01 flush, 10 lock, 11 quantum.
REQ-016 SHALL have busy, output, 1: high when state is not IDLE.
REQ-017 SHALL have auth_fault, output, 1: one-cycle pulse on a rejected request.
REQ-018 SHALL have fault_count, output, 8: saturating count of auth_fault pulses.

Function
REQ-019 SHALL give each request its own debounce counter: +1 per high sample, saturating at DEBOUNCE_CYCLES, cleared on any low sample; the request is qualified while the counter equals DEBOUNCE_CYCLES.
REQ-020 SHALL use the FSM states IDLE, QUANTUM, LOCK, FLUSH, COOLDOWN; all outputs are registered and updated on the same edge as the state.
REQ-021 SHALL resolve simultaneous qualified requests by fixed priority: quantum > lock > flush.
REQ-022 SHALL, in IDLE, enter QUANTUM on a qualified quantum request, with no authentication required.
REQ-023 SHALL, in IDLE, enter LOCK on a qualified lock request when authentication is valid or mission_profile==2'b11.
REQ-024 SHALL, in IDLE, enter FLUSH on a qualified flush request only when authentication is valid.
REQ-025 SHALL, in IDLE with a qualified lock or flush request lacking the required authentication, stay in IDLE and pulse auth_fault for one cycle; only one pulse per qualification episode, re-armed after that request's raw input goes low.
REQ-026 SHALL keep fault_count at 8'hFF without wrapping once it reaches 8'hFF.
REQ-027 SHALL, in QUANTUM, drive quantum_out=1 and lock_out=1 with active_source=11, and move to COOLDOWN on the first edge where raw quantum_req is sampled low.
REQ-028 SHALL, in LOCK, drive lock_out=1 with active_source=10, and move to COOLDOWN on the first edge where raw analog_lock_req is low and at least LOCK_MIN_HOLD cycles have elapsed in LOCK.
REQ-029 SHALL, in FLUSH, drive flush_out=1 with active_source=01 for exactly FLUSH_PULSE_CYCLES cycles, then move to COOLDOWN, regardless of the request level.
REQ-030 SHALL, in COOLDOWN, drive lock_out, flush_out and quantum_out low with active_source=00 and busy=1, and return to IDLE after exactly COOLDOWN_CYCLES cycles.
REQ-031 SHALL let a qualified quantum request preempt LOCK, FLUSH or COOLDOWN, entering QUANTUM on the next edge; a preempted flush pulse is truncated.
REQ-032 SHALL never preempt LOCK with a flush request, and SHALL ignore flush and lock requests outside IDLE; the debounce counters keep running in all states.
REQ-033 SHALL time latency from the first high sample: with a request held high from edge 1, it is qualified after edge DEBOUNCE_CYCLES and its output goes high after edge DEBOUNCE_CYCLES+1 (5 cycles at the default).
REQ-034 SHALL never assert flush_out together with lock_out or quantum_out.

Reset
REQ-035 SHALL, on reset, set the state to IDLE, clear all counters including fault_count, set all outputs to 0 and re-arm the fault logic, taking effect on the next edge even mid-operation.
REQ-036 SHALL require requests held high through reset to re-debounce from zero after reset deasserts.

Verification
REQ-037 SHALL cover: auth=1, lock_req high 3 cycles then low -> lock_out never asserts.
REQ-038 SHALL cover: auth=1, lock_req high edges 1..6 then low -> lock_out high after edge 5 for 8 cycles; busy low 4 cycles later.
REQ-039 SHALL cover: auth=0, profile=00, flush_req held 10 cycles -> single auth_fault pulse after edge 4, fault_count=1, flush_out never asserts.
REQ-040 SHALL cover: lock, flush and quantum all raised on the same edge with auth=1 -> quantum_out=lock_out=1 and active_source=11; flush_out stays 0.
REQ-041 SHALL cover: in the first FLUSH cycle, a quantum_req already qualified -> flush_out drops after 1 cycle and quantum_out rises on the same edge.
REQ-042 SHALL cover: reset pulsed for 1 cycle during LOCK while lock_req stays high -> all outputs 0 next edge; lock_out reasserts 5 cycles after reset deasserts.
